// File: rtl/clk_pwr_pkg.sv
// rtl/clk_pwr_pkg.sv - shared types, defaults and state decode for the clock/power controller
package clk_pwr_pkg;

    // Encoding is exported unchanged on state_o for telemetry.
    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_LIGHT  = 3'd3,
        ST_DEEP   = 3'd4
    } pwr_state_t;

    localparam int DEF_N_REQ      = 2;
    localparam int DEF_PU_CYC     = 8;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_IDLE_HOLD  = 4;
    localparam int DEF_TIMER_W    = 16;

    typedef struct packed {
        logic hf_pu;
        logic hf_en;
        logic osc_ready;
    } osc_outs_t;

    // Oscillator pin decode for a given state.
    function automatic osc_outs_t state_outs(input pwr_state_t st);
        osc_outs_t o;
        o = '{hf_pu: 1'b1, hf_en: 1'b0, osc_ready: 1'b0};
        unique case (st)
            ST_PWRUP:  o = '{hf_pu: 1'b1, hf_en: 1'b0, osc_ready: 1'b0};
            ST_SETTLE: o = '{hf_pu: 1'b1, hf_en: 1'b1, osc_ready: 1'b0};
            ST_RUN:    o = '{hf_pu: 1'b1, hf_en: 1'b1, osc_ready: 1'b1};
            ST_LIGHT:  o = '{hf_pu: 1'b1, hf_en: 1'b0, osc_ready: 1'b0};
            ST_DEEP:   o = '{hf_pu: 1'b0, hf_en: 1'b0, osc_ready: 1'b0};
            default:   o = '{hf_pu: 1'b1, hf_en: 1'b0, osc_ready: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/clk_pwr_ctrl_if.sv
// rtl/clk_pwr_ctrl_if.sv - request/wake inputs and oscillator/gate outputs of the controller
interface clk_pwr_if #(
    parameter int N_REQ   = clk_pwr_pkg::DEF_N_REQ,
    parameter int TIMER_W = clk_pwr_pkg::DEF_TIMER_W
);
    logic [N_REQ-1:0]   clk_req;
    logic               deep_en;
    logic               ext_wake;
    logic               wake_tmr_en;
    logic [TIMER_W-1:0] wake_tmr_val;
    logic               hf_pu;
    logic               hf_en;
    logic               osc_ready;
    logic [N_REQ-1:0]   gate_en;
    logic               wake_tmr_fire;
    logic [2:0]         state_o;

    // Requesters and system top level.
    modport master (
        output clk_req, deep_en, ext_wake, wake_tmr_en, wake_tmr_val,
        input  hf_pu, hf_en, osc_ready, gate_en, wake_tmr_fire, state_o
    );

    // The controller itself.
    modport slave (
        input  clk_req, deep_en, ext_wake, wake_tmr_en, wake_tmr_val,
        output hf_pu, hf_en, osc_ready, gate_en, wake_tmr_fire, state_o
    );
endinterface

// File: rtl/clk_pwr_ctrl_wake_timer.sv
// rtl/clk_pwr_ctrl_wake_timer.sv - sleep wake timer: loadable down-counter with one-cycle expiry pulse
module wake_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         run,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         fire
);
    logic [W-1:0] cnt;

    // Load on sleep entry, count down while sleeping and enabled, pulse on the first cycle at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            fire <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (load) begin
                cnt  <= load_val;
                fire <= en && (load_val == '0);
            end else if (run && en && (cnt != '0)) begin
                cnt  <= cnt - 1'b1;
                fire <= (cnt == W'(1));
            end
        end
    end
endmodule

// File: rtl/clk_pwr_ctrl.sv
// rtl/clk_pwr_ctrl.sv - HFOSC power sequencing FSM with request arbitration and clock gating
module clk_pwr_ctrl
    import clk_pwr_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int PU_CYC     = DEF_PU_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int IDLE_HOLD  = DEF_IDLE_HOLD,
    parameter int TIMER_W    = DEF_TIMER_W
) (
    input  logic     clk,
    input  logic     rst_n,
    clk_pwr_if.slave bus
);
    localparam int DLY_MAX = (PU_CYC > SETTLE_CYC) ? PU_CYC : SETTLE_CYC;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int IDLE_W  = $clog2(IDLE_HOLD + 1);

    pwr_state_t       state, state_nxt;
    logic [DLY_W-1:0] dly_cnt, dly_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    osc_outs_t        outs_q;
    logic [N_REQ-1:0] gate_q;
    logic             any_req;
    logic             wake;
    logic             sleep_now;
    logic             sleep_nxt;
    logic             tmr_load;
    logic             tmr_run;
    logic             tmr_fire;

    assign any_req   = |bus.clk_req;
    assign wake      = any_req | bus.ext_wake | tmr_fire;
    assign sleep_now = (state == ST_LIGHT) || (state == ST_DEEP);
    assign sleep_nxt = (state_nxt == ST_LIGHT) || (state_nxt == ST_DEEP);
    // The timer only counts while sleep continues, so it can never pulse in a wake state.
    assign tmr_load  = (state == ST_RUN) && sleep_nxt;
    assign tmr_run   = sleep_now && sleep_nxt;

    wake_timer #(.W(TIMER_W)) u_wake_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .run      (tmr_run),
        .en       (bus.wake_tmr_en),
        .load_val (bus.wake_tmr_val),
        .fire     (tmr_fire)
    );

    // Next-state, delay counter and idle counter decode.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        idle_nxt  = '0;
        unique case (state)
            ST_PWRUP: begin
                if (dly_cnt == DLY_W'(PU_CYC - 1)) begin
                    state_nxt = ST_SETTLE;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (dly_cnt == DLY_W'(SETTLE_CYC - 1)) begin
                    state_nxt = ST_RUN;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // A request arriving on the would-be sleep cycle wins and restarts the hold.
                if (any_req) begin
                    idle_nxt = '0;
                end else if (idle_cnt == IDLE_W'(IDLE_HOLD)) begin
                    state_nxt = bus.deep_en ? ST_DEEP : ST_LIGHT;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
            ST_LIGHT: begin
                if (wake) state_nxt = ST_SETTLE;
            end
            ST_DEEP: begin
                if (wake) state_nxt = ST_PWRUP;
            end
            default: begin
                state_nxt = ST_PWRUP;
                dly_nxt   = '0;
            end
        endcase
    end

    // State and counters; outputs are registered from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_PWRUP;
            dly_cnt  <= '0;
            idle_cnt <= '0;
            outs_q   <= state_outs(ST_PWRUP);
            gate_q   <= '0;
        end else begin
            state    <= state_nxt;
            dly_cnt  <= dly_nxt;
            idle_cnt <= idle_nxt;
            outs_q   <= state_outs(state_nxt);
            gate_q   <= (state_nxt == ST_RUN) ? bus.clk_req : '0;
        end
    end

    assign bus.hf_pu         = outs_q.hf_pu;
    assign bus.hf_en         = outs_q.hf_en;
    assign bus.osc_ready     = outs_q.osc_ready;
    assign bus.gate_en       = gate_q;
    assign bus.wake_tmr_fire = tmr_fire;
    assign bus.state_o       = state;
endmodule
